// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues one outstanding word read at a time and
// buffers returned {pc, instr} pairs in a DEPTH-entry FIFO in front of the datapath.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       imemReqValid,
    output logic [31:0]                imemReqAddr,
    input  logic                       imemReqReady,
    input  logic                       imemRspValid,
    input  logic [31:0]                imemRspData,
    input  logic                       redirectValid,
    input  logic [31:0]                redirectPC,
    output logic                       outValid,
    output logic [31:0]                outInstr,
    output logic [31:0]                outPC,
    output logic [31:0]                outPCPlus4,
    input  logic                       outReady,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [31:0]   r_q_instr [DEPTH];
    logic [31:0]   r_q_pc    [DEPTH];

    logic          w_pop;
    logic          w_push;
    logic          w_req_fire;
    logic [CW:0]   w_cnt_plus_pop;
    logic [CW:0]   w_cnt_after_push;
    logic [31:0]   w_redirect_pc;
    logic          w_unused_lsb;

    assign w_pop            = (r_count != '0) && outReady;
    assign w_req_fire       = (r_state == S_REQ) && imemReqReady;
    assign w_push           = (r_state == S_WAIT) && imemRspValid && !redirectValid;
    assign w_redirect_pc    = {redirectPC[31:2], 2'b00};
    assign w_unused_lsb     = ^redirectPC[1:0];
    assign w_cnt_plus_pop   = {1'b0, r_count} + (CW+1)'(w_pop);
    assign w_cnt_after_push = {1'b0, r_count} + (CW+1)'(1) - (CW+1)'(w_pop);

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Each request holds a FIFO slot from issue until its response, so a push never overflows.
    always_comb begin
        w_state_nxt  = r_state;
        imemReqValid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (redirectValid || (w_cnt_plus_pop < DEPTH_C)) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                imemReqValid = 1'b1;
                if (redirectValid)     w_state_nxt = imemReqReady ? S_DROP : S_REQ;
                else if (imemReqReady) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (redirectValid)     w_state_nxt = imemRspValid ? S_REQ : S_DROP;
                else if (imemRspValid) w_state_nxt = (w_cnt_after_push < DEPTH_C) ? S_REQ : S_IDLE;
            end
            S_DROP: begin
                if (imemRspValid) w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else if (redirectValid) begin
            r_fetch_pc <= w_redirect_pc;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
            if (w_push)     r_wr_ptr   <= r_wr_ptr + PW'(1);
            if (w_pop)      r_rd_ptr   <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // fetchPC has already advanced past the accepted request, hence the -4.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_q_instr[r_wr_ptr] <= imemRspData;
            r_q_pc[r_wr_ptr]    <= r_fetch_pc - 32'd4;
        end
    end

    assign imemReqAddr = r_fetch_pc;
    assign outValid    = (r_count != '0);
    assign outInstr    = r_q_instr[r_rd_ptr];
    assign outPC       = r_q_pc[r_rd_ptr];
    assign outPCPlus4  = r_q_pc[r_rd_ptr] + 32'd4;
    assign count       = r_count;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: a cycle table for steady fetch plus
// hand-written sequences for backpressure, redirects, PC wrap and mid-stream reset.
module tb_instr_fetch_queue;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance A: RESET_PC = 0
    logic        rst, req_v, req_r, rsp_v, redir_v, out_v, out_r;
    logic [31:0] req_a, rsp_d, redir_pc, out_i, out_pc, out_p4;
    logic [2:0]  cnt;
    // instance B: RESET_PC = FFFF_FFF8
    logic        b_rst, b_req_v, b_req_r, b_rsp_v, b_redir_v, b_out_v, b_out_r;
    logic [31:0] b_req_a, b_rsp_d, b_redir_pc, b_out_i, b_out_pc, b_out_p4;
    logic [2:0]  b_cnt;

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut_a (
        .clock(clk), .reset(rst), .imemReqValid(req_v), .imemReqAddr(req_a),
        .imemReqReady(req_r), .imemRspValid(rsp_v), .imemRspData(rsp_d),
        .redirectValid(redir_v), .redirectPC(redir_pc), .outValid(out_v),
        .outInstr(out_i), .outPC(out_pc), .outPCPlus4(out_p4), .outReady(out_r),
        .count(cnt));

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_b (
        .clock(clk), .reset(b_rst), .imemReqValid(b_req_v), .imemReqAddr(b_req_a),
        .imemReqReady(b_req_r), .imemRspValid(b_rsp_v), .imemRspData(b_rsp_d),
        .redirectValid(b_redir_v), .redirectPC(b_redir_pc), .outValid(b_out_v),
        .outInstr(b_out_i), .outPC(b_out_pc), .outPCPlus4(b_out_p4), .outReady(b_out_r),
        .count(b_cnt));

    int checks = 0;
    int errors = 0;

    // memory models (one outstanding request each)
    bit          a_pend, b_pend;
    int          a_left, a_lat;
    logic [31:0] a_paddr, b_paddr;
    logic [31:0] qa_pc[$], qa_in[$], qa_p4[$];
    logic [31:0] qb_pc[$], qb_in[$], qb_p4[$];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // one clock: drive memory responses, log pops, advance the memory models
    task automatic step();
        logic        a_acc, b_acc;
        logic [31:0] a_as, b_as;
        rsp_v   = a_pend && (a_left == 0);
        rsp_d   = mem_data(a_paddr);
        b_rsp_v = b_pend;
        b_rsp_d = mem_data(b_paddr);
        #1;
        a_acc = req_v && req_r;     a_as = req_a;
        b_acc = b_req_v && b_req_r; b_as = b_req_a;
        if (!rst && out_v && out_r) begin
            qa_pc.push_back(out_pc); qa_in.push_back(out_i); qa_p4.push_back(out_p4);
        end
        if (!b_rst && b_out_v && b_out_r) begin
            qb_pc.push_back(b_out_pc); qb_in.push_back(b_out_i); qb_p4.push_back(b_out_p4);
        end
        @(posedge clk);
        if (rst) a_pend = 1'b0;
        else begin
            if (rsp_v) a_pend = 1'b0;
            else if (a_pend && a_left > 0) a_left--;
            if (a_acc) begin a_pend = 1'b1; a_left = a_lat - 1; a_paddr = a_as; end
        end
        if (b_rst) b_pend = 1'b0;
        else begin
            b_pend = b_acc;
            if (b_acc) b_paddr = b_as;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; redir_v = 1'b0;
        step(); step();
        rst = 1'b0;
        qa_pc.delete(); qa_in.delete(); qa_p4.delete();
    endtask

    task automatic wait_cnt(input logic [2:0] tgt, input int budget, input string nm);
        int k = 0;
        while (cnt !== tgt && k < budget) begin step(); k++; end
        chk(nm, 32'(cnt), 32'(tgt));
    endtask

    task automatic collect_a(input int n, input int budget, input string nm);
        int k = 0;
        qa_pc.delete(); qa_in.delete(); qa_p4.delete();
        while (qa_pc.size() < n && k < budget) begin step(); k++; end
        chk(nm, 32'(qa_pc.size()), 32'(n));
    endtask

    typedef struct {
        logic        rst;
        logic        ordy;
        logic        ev;
        logic [31:0] ea;
        logic        eov;
        logic [31:0] epc;
        logic [2:0]  ecnt;
    } vec_t;

    vec_t tv[9];

    initial begin
        // zero-wait memory, datapath always ready: one instruction per 2 cycles
        tv[0] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0, 3'd0};
        tv[1] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0, 3'd0};
        tv[2] = '{1'b0, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0, 3'd0};
        tv[3] = '{1'b0, 1'b1, 1'b0, 32'h4,  1'b0, 32'h0, 3'd0};
        tv[4] = '{1'b0, 1'b1, 1'b1, 32'h4,  1'b1, 32'h0, 3'd1};
        tv[5] = '{1'b0, 1'b1, 1'b0, 32'h8,  1'b0, 32'h0, 3'd0};
        tv[6] = '{1'b0, 1'b1, 1'b1, 32'h8,  1'b1, 32'h4, 3'd1};
        tv[7] = '{1'b0, 1'b1, 1'b0, 32'hC,  1'b0, 32'h0, 3'd0};
        tv[8] = '{1'b0, 1'b1, 1'b1, 32'hC,  1'b1, 32'h8, 3'd1};

        rst = 1'b1; req_r = 1'b1; redir_v = 1'b0; redir_pc = '0; out_r = 1'b1;
        rsp_v = 1'b0; rsp_d = '0;
        b_rst = 1'b1; b_req_r = 1'b1; b_redir_v = 1'b0; b_redir_pc = '0; b_out_r = 1'b1;
        b_rsp_v = 1'b0; b_rsp_d = '0;
        a_pend = 1'b0; b_pend = 1'b0; a_left = 0; a_lat = 1; a_paddr = '0; b_paddr = '0;
        step(); step();

        for (int i = 0; i < 9; i++) begin
            rst   = tv[i].rst;
            out_r = tv[i].ordy;
            chk($sformatf("t1_reqv[%0d]", i), 32'(req_v), 32'(tv[i].ev));
            chk($sformatf("t1_reqa[%0d]", i), req_a, tv[i].ea);
            chk($sformatf("t1_outv[%0d]", i), 32'(out_v), 32'(tv[i].eov));
            chk($sformatf("t1_cnt[%0d]", i), 32'(cnt), 32'(tv[i].ecnt));
            if (tv[i].eov) begin
                chk($sformatf("t1_pc[%0d]", i), out_pc, tv[i].epc);
                chk($sformatf("t1_pc4[%0d]", i), out_p4, tv[i].epc + 32'd4);
                chk($sformatf("t1_instr[%0d]", i), out_i, mem_data(tv[i].epc));
            end
            step();
        end

        // backpressure: fill to 4, no fetch while full, then drain without losing data
        do_reset();
        out_r = 1'b0; a_lat = 1;
        wait_cnt(3'd4, 40, "t2_fill");
        for (int i = 0; i < 5; i++) begin
            chk("t2_full_reqv", 32'(req_v), 32'h0);
            chk("t2_full_cnt", 32'(cnt), 32'd4);
            chk("t2_full_head", out_pc, 32'h0);
            step();
        end
        out_r = 1'b1;
        collect_a(6, 60, "t2_drain_count");
        for (int i = 0; i < 6; i++) begin
            chk("t2_drain_pc", qa_pc[i], 32'(i * 4));
            chk("t2_drain_instr", qa_in[i], mem_data(32'(i * 4)));
        end

        // redirect while in WAIT with entries 0x10.. queued
        do_reset();
        out_r = 1'b0; a_lat = 1;
        redir_v = 1'b1; redir_pc = 32'h10;
        step();
        redir_v = 1'b0;
        chk("t3_req_at_0x10", req_a, 32'h10);
        wait_cnt(3'd3, 40, "t3_fill3");
        chk("t3_req_1c_v", 32'(req_v), 32'h1);
        chk("t3_req_1c_a", req_a, 32'h1C);
        a_lat = 3;
        step();
        chk("t3_wait_cnt", 32'(cnt), 32'd3);
        chk("t3_wait_head", out_pc, 32'h10);
        redir_v = 1'b1; redir_pc = 32'h400;
        step();
        redir_v = 1'b0;
        chk("t3_flush_cnt", 32'(cnt), 32'd0);
        chk("t3_flush_outv", 32'(out_v), 32'h0);
        chk("t3_drop_reqv", 32'(req_v), 32'h0);
        chk("t3_drop_addr", req_a, 32'h400);
        a_lat = 1; out_r = 1'b1;
        collect_a(2, 30, "t3_deliver");
        chk("t3_pc0", qa_pc[0], 32'h400);
        chk("t3_pc4_0", qa_p4[0], 32'h404);
        chk("t3_instr0", qa_in[0], mem_data(32'h400));
        chk("t3_pc1", qa_pc[1], 32'h404);

        // redirect (misaligned target) in the same cycle the request is accepted
        do_reset();
        out_r = 1'b1; a_lat = 3;
        begin
            int k = 0;
            while (req_v !== 1'b1 && k < 10) begin step(); k++; end
        end
        chk("t4_req_seen", 32'(req_v), 32'h1);
        redir_v = 1'b1; redir_pc = 32'h203;
        step();
        redir_v = 1'b0;
        chk("t4_drop_reqv", 32'(req_v), 32'h0);
        chk("t4_drop_addr", req_a, 32'h200);
        chk("t4_drop_outv", 32'(out_v), 32'h0);
        step();
        chk("t4_drop_hold", 32'(req_v), 32'h0);
        a_lat = 1;
        collect_a(2, 30, "t4_deliver");
        chk("t4_pc0", qa_pc[0], 32'h200);
        chk("t4_instr0", qa_in[0], mem_data(32'h200));
        chk("t4_pc1", qa_pc[1], 32'h204);

        // reset mid-stream with 3 entries queued and a fetch outstanding
        do_reset();
        out_r = 1'b0; a_lat = 1;
        wait_cnt(3'd3, 40, "t6_fill3");
        a_lat = 3;
        step();
        chk("t6_pre_cnt", 32'(cnt), 32'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_cnt", 32'(cnt), 32'd0);
        chk("t6_outv", 32'(out_v), 32'h0);
        chk("t6_reqv", 32'(req_v), 32'h0);
        chk("t6_reqa", req_a, 32'h0);
        step();
        chk("t6_resume_v", 32'(req_v), 32'h1);
        chk("t6_resume_a", req_a, 32'h0);

        // PC wrap on the high-RESET_PC instance
        chk("t5_rst_outv", 32'(b_out_v), 32'h0);
        chk("t5_rst_addr", b_req_a, 32'hFFFF_FFF8);
        chk("t5_rst_cnt", 32'(b_cnt), 32'd0);
        b_rst = 1'b0;
        begin
            int k = 0;
            while (qb_pc.size() < 3 && k < 30) begin step(); k++; end
        end
        chk("t5_count", 32'(qb_pc.size()), 32'd3);
        chk("t5_pc0", qb_pc[0], 32'hFFFF_FFF8);
        chk("t5_pc1", qb_pc[1], 32'hFFFF_FFFC);
        chk("t5_pc2", qb_pc[2], 32'h0000_0000);
        chk("t5_pc4_1", qb_p4[1], 32'h0000_0000);
        chk("t5_instr2", qb_in[2], mem_data(32'h0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
